// File: rtl/fft_pipe_stream.sv
// Streaming N-point radix-2 DIT FFT: input register plus one registered butterfly column per stage.
// Optional inverse-transform tagging is compiled in with `define FFT_PIPE_STREAM_IFFT_EN.
module fft_pipe_stream #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 16,
  parameter int unsigned SCALE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*DW*(1<<LOG2N)-1:0] in_data,
`ifdef FFT_PIPE_STREAM_IFFT_EN
  input  logic                       in_inv,
  output logic                       out_inv,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*DW*(1<<LOG2N)-1:0] out_data,
  input  logic                       tw_we,
  input  logic [LOG2N-2:0]           tw_addr,
  input  logic [2*TW-1:0]            tw_wdata,
  output logic                       busy,
  output logic                       ovf
);
  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned FW = 2 * DW * N;
  localparam logic signed [DW+TW:0] Rnd   = (DW+TW+1)'(1) << (TW - 2);
  localparam logic [2*TW-1:0]       TwOne = {{TW{1'b0}}, 1'b0, {(TW-1){1'b1}}};

  typedef struct packed {
    logic          sat;
    logic [2*DW-1:0] y1;
    logic [2*DW-1:0] y0;
  } bfly_t;

  // Optional halving with round-half-up, then clamp; MSB of the result flags a clamp.
  function automatic logic [DW:0] sat_rnd(input logic signed [DW+1:0] x);
    logic signed [DW+1:0] s;
    logic signed [DW+1:0] hi;
    logic signed [DW+1:0] lo;
    hi = {3'b000, {(DW-1){1'b1}}};
    lo = {3'b111, {(DW-1){1'b0}}};
    s  = (SCALE != 0) ? ((x + (DW+2)'(1)) >>> 1) : x;
    if (s > hi) begin
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    end else if (s < lo) begin
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, s[DW-1:0]};
    end
  endfunction

  function automatic bfly_t bfly(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                 input logic [2*TW-1:0] w, input logic inv);
    logic signed [DW+TW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [DW+TW:0]   pr, pi;
    logic signed [DW+1:0]    wbr, wbi, ar, ai;
    logic [DW:0]             r0, i0, r1, i1;
    bfly_t                   res;
    m_rr = (DW+TW)'($signed(b[DW-1:0]))    * (DW+TW)'($signed(w[TW-1:0]));
    m_ii = (DW+TW)'($signed(b[2*DW-1:DW])) * (DW+TW)'($signed(w[2*TW-1:TW]));
    m_ri = (DW+TW)'($signed(b[DW-1:0]))    * (DW+TW)'($signed(w[2*TW-1:TW]));
    m_ir = (DW+TW)'($signed(b[2*DW-1:DW])) * (DW+TW)'($signed(w[TW-1:0]));
    // Inverse frames multiply by conj(W).
    if (inv) begin
      pr = (DW+TW+1)'(m_rr) + (DW+TW+1)'(m_ii);
      pi = (DW+TW+1)'(m_ir) - (DW+TW+1)'(m_ri);
    end else begin
      pr = (DW+TW+1)'(m_rr) - (DW+TW+1)'(m_ii);
      pi = (DW+TW+1)'(m_ri) + (DW+TW+1)'(m_ir);
    end
    wbr = (DW+2)'((pr + Rnd) >>> (TW - 1));
    wbi = (DW+2)'((pi + Rnd) >>> (TW - 1));
    ar  = (DW+2)'($signed(a[DW-1:0]));
    ai  = (DW+2)'($signed(a[2*DW-1:DW]));
    r0  = sat_rnd(ar + wbr);
    i0  = sat_rnd(ai + wbi);
    r1  = sat_rnd(ar - wbr);
    i1  = sat_rnd(ai - wbi);
    res.sat = r0[DW] | i0[DW] | r1[DW] | i1[DW];
    res.y0  = {i0[DW-1:0], r0[DW-1:0]};
    res.y1  = {i1[DW-1:0], r1[DW-1:0]};
    return res;
  endfunction

  logic [FW-1:0]    data_q  [LOG2N+1];
  logic [FW-1:0]    stage_y [LOG2N];
  logic [LOG2N-1:0] stage_sat;
  logic [LOG2N-1:0] stage_inv;
  logic [LOG2N:0]   v_q;
  logic [LOG2N:0]   rdy;
  logic [2*TW-1:0]  tw_q [N/2];
  logic             ovf_q;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int unsigned H = 1 << s;
    logic [FW-1:0] y;
    logic          sat;
    always_comb begin
      int unsigned     p;
      logic [LOG2N-2:0] k;
      bfly_t           bf;
      y   = '0;
      sat = 1'b0;
      p   = 0;
      k   = '0;
      bf  = '0;
      for (int j = 0; j < N / 2; j++) begin
        // j enumerates pairs; p is the lower index of the pair (bit s clear).
        p  = ((j >> s) << (s + 1)) | (j & (H - 1));
        k  = (LOG2N-1)'((j & (H - 1)) << (LOG2N - 1 - s));
        bf = bfly(data_q[s][p*2*DW +: 2*DW], data_q[s][(p+H)*2*DW +: 2*DW], tw_q[k],
                  stage_inv[s]);
        y[p*2*DW +: 2*DW]     = bf.y0;
        y[(p+H)*2*DW +: 2*DW] = bf.y1;
        sat = sat | bf.sat;
      end
    end
    assign stage_y[s]   = y;
    assign stage_sat[s] = sat;
  end

  always_comb begin
    rdy        = '0;
    rdy[LOG2N] = ~v_q[LOG2N] | out_ready;
    for (int i = int'(LOG2N) - 1; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i <= LOG2N; i++) data_q[i] <= '0;
    end else begin
      if (rdy[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) data_q[0] <= in_data;
      end
      for (int i = 0; i < LOG2N; i++) begin
        if (rdy[i+1]) begin
          v_q[i+1] <= v_q[i];
          if (v_q[i]) data_q[i+1] <= stage_y[i];
        end
      end
      ovf_q <= ovf_q | (|(stage_sat & v_q[LOG2N-1:0] & rdy[LOG2N:1]));
    end
  end

  // Table updates only while the pipe is empty so a frame never sees a mixed table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N / 2; i++) tw_q[i] <= (i == 0) ? TwOne : '0;
    end else if (tw_we && !busy && !in_valid) begin
      tw_q[tw_addr] <= tw_wdata;
    end
  end

`ifdef FFT_PIPE_STREAM_IFFT_EN
  logic [LOG2N:0] inv_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q <= '0;
    end else begin
      if (rdy[0] && in_valid) inv_q[0] <= in_inv;
      for (int i = 0; i < LOG2N; i++) begin
        if (rdy[i+1] && v_q[i]) inv_q[i+1] <= inv_q[i];
      end
    end
  end
  assign stage_inv = inv_q[LOG2N-1:0];
  assign out_inv   = inv_q[LOG2N];
`else
  assign stage_inv = '0;
`endif

  assign in_ready  = rdy[0];
  assign out_valid = v_q[LOG2N];
  assign out_data  = data_q[LOG2N];
  assign busy      = |v_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_pipe_stream.sv
// Directed bench for fft_pipe_stream: 8-point scaled instance plus an unscaled instance for overflow.
`timescale 1ns/1ps
module tb_fft_pipe_stream;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned N     = 8;
  localparam int unsigned FW    = 2 * DW * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [FW-1:0] in_data = '0, out_data;
  logic          tw_we = 1'b0;
  logic [1:0]    tw_addr = '0;
  logic [31:0]   tw_wdata = '0;
  logic          busy, ovf;

  logic          ns_in_valid = 1'b0, ns_in_ready, ns_out_valid, ns_out_ready = 1'b1;
  logic [FW-1:0] ns_in_data = '0, ns_out_data;
  logic          ns_tw_we = 1'b0;
  logic [1:0]    ns_tw_addr = '0;
  logic [31:0]   ns_tw_wdata = '0;
  logic          ns_busy, ns_ovf;
`ifdef FFT_PIPE_STREAM_IFFT_EN
  logic in_inv = 1'b0, out_inv, ns_in_inv = 1'b0, ns_out_inv;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_pipe_stream #(.LOG2N(LOG2N), .DW(DW), .TW(TW), .SCALE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef FFT_PIPE_STREAM_IFFT_EN
    .in_inv(in_inv), .out_inv(out_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .tw_we(tw_we),
    .tw_addr(tw_addr), .tw_wdata(tw_wdata), .busy(busy), .ovf(ovf)
  );

  fft_pipe_stream #(.LOG2N(LOG2N), .DW(DW), .TW(TW), .SCALE(0)) dut_ns (
    .clk(clk), .reset(reset), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_data(ns_in_data),
`ifdef FFT_PIPE_STREAM_IFFT_EN
    .in_inv(ns_in_inv), .out_inv(ns_out_inv),
`endif
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
    .tw_we(ns_tw_we), .tw_addr(ns_tw_addr), .tw_wdata(ns_tw_wdata), .busy(ns_busy),
    .ovf(ns_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pt(input int re, input int im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {i, r};
  endfunction

  function automatic logic [FW-1:0] frame8(input logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [FW-1:0] imp(input int slot, input int val);
    logic [FW-1:0] f;
    f = '0;
    f[slot*32 +: 32] = pt(val, 0);
    return f;
  endfunction

  function automatic logic [FW-1:0] uni(input int val);
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*32 +: 32] = pt(val, 0);
    return f;
  endfunction

  task automatic tw_write(input logic [1:0] a, input logic [31:0] d);
    tw_we    = 1'b1;
    tw_addr  = a;
    tw_wdata = d;
    tick();
    tw_we    = 1'b0;
  endtask

  // Push one frame with out_ready high and compare every output point.
  task automatic run_frame(input string tag, input logic [FW-1:0] f, input logic [FW-1:0] e);
    int lat;
    in_data  = f;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, LOG2N + 1);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_pt%0d", tag, k), out_data[k*32 +: 32], e[k*32 +: 32]);
    tick();
  endtask

  task automatic ns_frame(input logic [FW-1:0] f, output logic [FW-1:0] o);
    int lat;
    ns_in_data  = f;
    ns_in_valid = 1'b1;
    tick();
    ns_in_valid = 1'b0;
    lat = 1;
    while (!ns_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("ns_latency", lat, LOG2N + 1);
    o = ns_out_data;
    tick();
  endtask

  initial begin
    logic [FW-1:0] o;
    int cnt;

    // Reset state
    #2 reset = 1'b0;
    #6;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, '0);
    @(negedge clk) reset = 1'b1;
    tick();

    // cos/sin table, W^k = exp(-j*2*pi*k/8) in Q1.15
    tw_write(2'd0, {16'h0000, 16'h7FFF});
    tw_write(2'd1, {16'hA57E, 16'h5A82});
    tw_write(2'd2, {16'h8001, 16'h0000});
    tw_write(2'd3, {16'hA57E, 16'hA57E});

    run_frame("impulse", imp(0, 4096), uni(512));
    chk("impulse_ovf", ovf, 0);

    run_frame("dc", uni(4096), imp(0, 4096));

    // Bit-reversed slot 5 is natural point 5: X[k] = 512*exp(-j*5*pi*k/4)
    run_frame("tone5", imp(5, 4096),
              frame8(pt(512, 0), pt(-362, 362), pt(0, -512), pt(362, 362),
                     pt(-512, 0), pt(362, -362), pt(0, 512), pt(-362, -362)));
    chk("tone5_ovf", ovf, 0);

    // Write attempted while busy must be dropped
    in_data  = imp(1, 4096);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("twbusy_busy", busy, 1);
    tw_write(2'd0, {16'h0000, 16'h4000});
    cnt = 0;
    while (busy && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("twbusy_drain", busy, 0);
    run_frame("twbusy", imp(1, 4096),
              frame8(pt(512, 0), pt(-512, 0), pt(512, 0), pt(-512, 0),
                     pt(512, 0), pt(-512, 0), pt(512, 0), pt(-512, 0)));

    // Idle write takes effect: W0 = 0.5 halves the result
    tw_write(2'd0, {16'h0000, 16'h4000});
    run_frame("twidle", imp(1, 4096),
              frame8(pt(256, 0), pt(-256, 0), pt(256, 0), pt(-256, 0),
                     pt(256, 0), pt(-256, 0), pt(256, 0), pt(-256, 0)));
    tw_write(2'd0, {16'h0000, 16'h7FFF});

    // Backpressure: four registers fill, then in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = imp(0, 4096 * ((i < 4 ? i : 4) + 1));
      chk($sformatf("bp_in_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_data", out_data[31:0], pt(512, 0));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_out_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_out_pt0_%0d", i), out_data[31:0], pt(512 * (i + 1), 0));
      chk($sformatf("bp_out_pt7_%0d", i), out_data[255:224], pt(512 * (i + 1), 0));
      tick();
    end
    chk("bp_no_dup", out_valid, 0);
    chk("bp_idle", busy, 0);

    // Unscaled instance saturates on a full-scale DC frame
    ns_frame(uni(32767), o);
    chk("ovf_x0", o[31:0], pt(32767, 0));
    chk("ovf_flag", ns_ovf, 1);
    ns_frame('0, o);
    chk("ovf_clean_x0", o[31:0], pt(0, 0));
    chk("ovf_sticky", ns_ovf, 1);
    chk("ovf_other_dut", ovf, 0);

    // Reset mid-frame discards the frame in flight
    in_data  = uni(4096);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_data", out_data, '0);
    chk("mrst_ns_ovf", ns_ovf, 0);
    @(negedge clk) reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("mrst_discard", cnt, 0);
    run_frame("post_rst", imp(0, 4096), uni(512));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
